// File: rtl/truth_table_scanner.sv
// Walks every N-bit input vector through a combinational block, samples f after
// a programmable settle time and accumulates the minterm mask plus a ones count.
module truth_table_scanner #(
  parameter int unsigned N      = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               f,
  output logic [N-1:0]       vec,
  output logic               busy,
  output logic               done,
  output logic [(1<<N)-1:0]  minterms,
  output logic [N:0]         ones,
  output logic               const0,
  output logic               const1
);

  localparam int unsigned NV = 1 << N;
  localparam int unsigned WW = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NV-1:0]   minterms_q, minterms_d;
  logic [N:0]      ones_q, ones_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      minterms_q <= '0;
      ones_q     <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      minterms_q <= minterms_d;
      ones_q     <= ones_d;
    end
  end

  // Next-state, vector sequencing and capture
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    wait_d     = wait_q;
    minterms_d = minterms_q;
    ones_d     = ones_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          vec_d      = '0;
          wait_d     = '0;
          minterms_d = '0;
          ones_d     = '0;
        end
      end
      RUN: begin
        if (wait_q != WW'(SETTLE)) begin
          wait_d = wait_q + WW'(1);
        end else begin
          // Sampling edge: f has been stable for SETTLE+1 cycles
          minterms_d[vec_q] = f;
          ones_d            = ones_q + (N+1)'(f);
          wait_d            = '0;
          if (vec_q == N'(NV - 1)) begin
            state_d = DONE;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + N'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign vec      = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign minterms = minterms_q;
  assign ones     = ones_q;
  assign const0   = (ones_q == '0);
  assign const1   = (ones_q == (N+1)'(NV));

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus/capture engine for combinational logic blocks with up to N inputs. On `start` it drives every input vector 0 .. 2^N-1 onto the DUT inputs, waits a programmable settle time, and samples the DUT output for each vector. It assembles the complete minterm mask and a ones count, from which the sum-of-products (mask) or product-of-sums (inverted mask) form can be read directly. It is the capture side of the team's SoP/PoS function blocks and replaces ad-hoc testbench loops with a synthesizable on-chip checker.

## Interface
- `N`, 3: number of DUT inputs; legal range 1..6.
- `SETTLE`, 1: cycles the vector is held before the sampling edge; legal range 0..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a scan; honoured only in IDLE.
- `f`  in  1  DUT output, combinationally driven from `vec`.
- `vec`  out  N  current input vector to the DUT; MSB maps to the first DUT input (A).
- `busy`  out  1  high while a scan is in progress (RUN state).
- `done`  out  1  single-cycle pulse when the scan completes.
- `minterms`  out  2^N  bit i holds f sampled with vec == i.
- `ones`  out  N+1  number of set bits in `minterms`.
- `const0`  out  1  high when ones == 0.
- `const1`  out  1  high when ones == 2^N.

## Operation
- States: IDLE, RUN, DONE.
- Reset, asynchronous with rst_n low, forces:
  - state = IDLE
  - vec = 0, wait counter = 0
  - busy = 0, done = 0
  - minterms = 0, ones = 0
  - so const0 = 1 and const1 = 0.
- IDLE with start = 1 at an edge:
  - state goes to RUN, vec = 0, wait = 0.
  - minterms and ones clear to 0.
  - start in RUN or DONE is ignored, with no restart.
- RUN, on each edge:
  - If wait < SETTLE: wait increments.
  - If wait == SETTLE:
    - minterms[vec] <= f, ones <= ones + f, wait <= 0.
    - If vec == 2^N-1: state goes to DONE and vec goes to 0.
    - Otherwise vec increments.
- DONE: one cycle with done = 1, then unconditionally to IDLE.
- `minterms` and `ones` hold their final values in IDLE until the next accepted start or reset.
- `const0`/`const1` are combinational from `ones`. They are meaningful only when busy = 0.
- f is sampled only at the sampling edge. Values of f between sampling edges are ignored, so glitches while the DUT settles are don't-care.
- `ones` never overflows: its maximum is 2^N, which fits in N+1 bits.
- Reset asserted mid-scan aborts immediately with no done pulse and all outputs at reset values.

## Timing
- busy = (state == RUN), registered.
- done = (state == DONE), registered.
- Each vector is held SETTLE+1 cycles. Full scan = 2^N*(SETTLE+1) cycles in RUN, plus 1 DONE cycle.
- Latency from the start-accept edge to the done pulse = 2^N*(SETTLE+1) cycles. Example: N=3, SETTLE=1 gives 16 cycles, with done visible in the cycle after the 16th RUN cycle.
- The sampling edge for vector i is edge i*(SETTLE+1)+SETTLE+1 after start-accept. With SETTLE = 0, f is sampled at the first edge after vec changes.
- minterms[i] is updated at that vector's sampling edge. Lower bits fill first; the final mask is stable when done = 1.
- start held high continuously: a new scan starts on the first IDLE edge after DONE, so scans repeat back-to-back with one idle cycle between.

## Test plan
- Reset, then N=3, SETTLE=1, with f driven by F = ~A~B~C + ~AB~C + A~B~C + A~BC (vec = {A,B,C}); pulse start:
  - done is seen 16 cycles after accept
  - minterms = 8'b00110101, ones = 4, const0 = const1 = 0.
- f tied to 1, SETTLE=0:
  - scan takes 8 cycles
  - minterms = 8'hFF, ones = 8, const1 = 1.
- f tied to 0:
  - minterms = 0, ones = 0, const0 = 1
  - done pulses exactly once, 1 cycle wide.
- Pulse start again at cycle 5 of a running scan:
  - ignored; done occurs at the original time with the same result.
- Assert rst_n low at cycle 7 of a scan:
  - busy, vec, minterms and ones go to 0 immediately, no done pulse
  - a subsequent start gives a correct full scan.
- SETTLE=3, f = vec[0] with a one-cycle glitch injected just after each vec change:
  - minterms = 8'b10101010, proving sampling only at the settle edge.
